// File: rtl/pc_flow_controller.sv
// Program counter sequencing for the 8-bit single-cycle core: PC register, PC+4 / target mux,
// busy-wait hold and a saturating redirect counter.
//   state | meaning
//   BOOT  | PC parked at RESET_VECTOR, no instruction executing
//   RUN   | instruction executing, PC advances each edge
//   STALL | memory busy-wait, PC held until release edge
`timescale 1ns/1ps
module pc_flow_controller #(
    parameter int unsigned           PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                busywait,
    input  logic                jump,
    input  logic                branch_eq,
    input  logic                branch_ne,
    input  logic                zero,
    input  logic [7:0]          offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] target,
    output logic                flow_select,
    output logic                instr_valid,
    output logic                stalled,
    output logic [15:0]         redirect_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                taken;
    logic                commit;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] offset_ext;

    // Word offset scaled to bytes and sign-extended to the PC width.
    assign offset_ext = {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};
    assign pc_plus4   = pc + {{(PC_WIDTH-3){1'b0}}, 3'b100};
    assign target     = pc_plus4 + offset_ext;
    assign taken      = jump | (branch_eq & zero) | (branch_ne & ~zero);
    assign next_pc    = flow_select ? target : pc_plus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_valid = 1'b0;
        stalled     = 1'b0;
        commit      = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                instr_valid = 1'b1;
                commit      = ~busywait;
                state_nxt   = busywait ? STALL : RUN;
            end
            STALL: begin
                instr_valid = 1'b1;
                stalled     = 1'b1;
                commit      = ~busywait;
                state_nxt   = busywait ? STALL : RUN;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
        flow_select = taken & instr_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (commit) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_count <= 16'h0000;
        end else if (commit && flow_select && (redirect_count != 16'hFFFF)) begin
            redirect_count <= redirect_count + 16'h0001;
        end
    end

endmodule
